instr_decode_monitor: RTL
=========================

// Module: instr_decode_monitor
// PURPOSE
//  Receive end of the CPU instruction interface: takes 32-bit RV32I words and decodes them
//  back into cpu_pkg::op_e plus register/immediate fields.
//  Covers ADDI, ADD, SUB, AND, OR and SLT; any other encoding is flagged illegal.
//  Decoded results go into a 2-entry output buffer with valid/ready on both sides.
//  Keeps saturating per-op and illegal counters for scoreboarding and coverage.
// PARAMETERS
//  CNT_W  16  width of every statistics counter (saturating)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      instr is valid this cycle
//  in_ready     out  1      decoder can accept instr this cycle
//  instr        in   32     RV32I instruction word
//  out_valid    out  1      head buffer entry is valid
//  out_ready    in   1      consumer takes the head entry this cycle
//  out_op       out  op_e   decoded operation ('0 when illegal)
//  out_rd       out  5      instr[11:7]
//  out_rs1      out  5      instr[19:15]
//  out_rs2      out  5      instr[24:20] for R-type; 0 for ADDI
//  out_imm      out  12     instr[31:20] for ADDI; 0 for R-type
//  out_illegal  out  1      head entry is an unsupported encoding
//  cnt_sel      in   3      op_e index selecting the counter shown on cnt_val
//  cnt_val      out  CNT_W  count of accepted instrs decoding to op cnt_sel
//  illegal_cnt  out  CNT_W  count of accepted illegal instrs
// BEHAVIOUR
//  - Handshake
//    - Accept = in_valid & in_ready.
//    - Pop = out_valid & out_ready.
//    - in_ready = !rst & (occupancy < 2), combinational from the registered occupancy.
//  - Decode (combinational, applied on accept)
//    - opcode 0010011, f3 000                -> ADDI
//    - opcode 0110011, f3 000, f7 0000000    -> ADD
//    - opcode 0110011, f3 000, f7 0100000    -> SUB
//    - opcode 0110011, f3 111, f7 0000000    -> AND
//    - opcode 0110011, f3 110, f7 0000000    -> OR
//    - opcode 0110011, f3 010, f7 0000000    -> SLT
//    - Anything else -> illegal: out_illegal=1, op='0.
//    - rd/rs1 are still extracted on illegal; rs2/imm are 0.
//  - Latency
//    - A word accepted at edge N is visible on out_* with out_valid=1 after edge N,
//      provided the buffer was empty.
//    - out_* always reflect the head entry; entries leave in FIFO order.
//  - Occupancy boundaries
//    - 0: out_valid=0; out_* data holds last value (don't-care).
//    - 2: in_ready=0, so an in_valid word is held off, not dropped.
//    - 1 with accept and pop in the same cycle: occupancy stays 1 and the new entry becomes head.
//    - Pop when empty is ignored.
//  - Counters
//    - Increment on accept, not on pop.
//    - Saturate at 2**CNT_W-1; no wrap.
//    - A cnt_sel value outside the op_e range returns 0.
//  - Reset (rst=1 at an edge, including mid-stream)
//    - Buffer is flushed: occupancy 0, out_valid=0, storage zeroed.
//    - All counters go to 0.
//    - in_ready=0 while rst=1.
//    - Anything presented during reset is discarded.
// STRUCTURE
//  - cpu_pkg (shared)
//    - op_e.
//    - Constants OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011.
//    - F3_ADD_SUB/F3_AND/F3_OR/F3_SLT, F7_BASE=7'b0000000, F7_SUB=7'b0100000.
//    - Struct dec_s = {op, rd, rs1, rs2, imm, illegal}.
//  - Sub-module dec_fifo2: 2-entry synchronous FIFO of dec_s with push/pop/full/empty.
//  - Top level holds the decode logic and the counters.
// TESTING
//  1. Buffer empty, out_ready=1; push 0x00700293 -> next cycle out_valid=1, ADDI,
//     rd=5, rs1=0, imm=7, rs2=0, illegal=0.
//  2. Push 0x402081B3 -> SUB, rd=3, rs1=1, rs2=2.
//     Same word with f7=0000001 -> illegal=1, illegal_cnt=1.
//  3. out_ready=0, in_valid held high for 3 words -> 2 accepted, then in_ready=0.
//     Release out_ready -> words pop in order, none lost or duplicated.
//  4. Occupancy 1, push and pop in the same cycle -> occupancy stays 1 and the new word
//     becomes head.
//  5. CNT_W=2; accept 5 ADD -> cnt_val(sel=ADD)=3, saturated.
//  6. Two entries buffered, assert rst for 1 cycle -> out_valid=0, all counts 0,
//     in_ready=1 once rst drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU instruction-interface types, encodings and the RV32I subset decoder.
package cpu_pkg;

   localparam int unsigned NUM_OPS = 6;

   typedef enum logic [2:0] {
      OP_ADDI = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_SLT  = 3'd5
   } op_e;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;

   typedef struct packed {
      op_e         op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm;
      logic        illegal;
   } dec_s;

   // Decode one word; unsupported encodings keep rd/rs1 and zero op/rs2/imm.
   function automatic dec_s decode(input logic [31:0] instr);
      dec_s       d;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc       = instr[6:0];
      f3        = instr[14:12];
      f7        = instr[31:25];
      d         = '0;
      d.rd      = instr[11:7];
      d.rs1     = instr[19:15];
      d.illegal = 1'b1;
      if (opc == OPC_OP_IMM && f3 == F3_ADD_SUB) begin
         d.op      = OP_ADDI;
         d.imm     = instr[31:20];
         d.illegal = 1'b0;
      end else if (opc == OPC_OP) begin
         d.illegal = 1'b0;
         if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
            d.op = OP_SUB;
         end else if (f7 == F7_BASE) begin
            case (f3)
               F3_ADD_SUB: d.op = OP_ADD;
               F3_AND:     d.op = OP_AND;
               F3_OR:      d.op = OP_OR;
               F3_SLT:     d.op = OP_SLT;
               default:    d.illegal = 1'b1;
            endcase
         end else begin
            d.illegal = 1'b1;
         end
         if (!d.illegal) d.rs2 = instr[24:20];
         else            d.op  = op_e'(3'd0);
      end
      return d;
   endfunction

endpackage

// File: rtl/dec_fifo2.sv
// Two-entry synchronous FIFO of decoded instructions; head is always on rdata.
module dec_fifo2
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  dec_s wdata,
   output dec_s rdata,
   output logic full,
   output logic empty
);

   logic [1:0] cnt;
   logic       wr_ptr;
   logic       rd_ptr;
   dec_s       mem [2];
   logic       do_push;
   logic       do_pop;

   assign full    = (cnt == 2'd2);
   assign empty   = (cnt == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage, pointers and occupancy; reset flushes and zeroes the storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/instr_decode_monitor.sv
// Receive-side RV32I subset decoder with a 2-entry output buffer and saturating stats.
module instr_decode_monitor
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output op_e              out_op,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [11:0]      out_imm,
   output logic             out_illegal,
   input  logic [2:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_val,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             full;
   logic             empty;
   logic             accept;
   logic             pop;
   dec_s             dec_c;
   dec_s             head;
   logic [CNT_W-1:0] op_cnt [NUM_OPS];

   assign in_ready  = ~rst & ~full;
   assign accept    = in_valid & in_ready;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign dec_c     = decode(instr);

   dec_fifo2 u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .wdata (dec_c),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign out_op      = head.op;
   assign out_rd      = head.rd;
   assign out_rs1     = head.rs1;
   assign out_rs2     = head.rs2;
   assign out_imm     = head.imm;
   assign out_illegal = head.illegal;

   assign cnt_val = (32'(cnt_sel) < NUM_OPS) ? op_cnt[cnt_sel] : '0;

   // Saturating per-op and illegal counters, bumped on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_OPS; i++) op_cnt[i] <= '0;
         illegal_cnt <= '0;
      end else if (accept) begin
         if (dec_c.illegal) begin
            if (illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + CNT_W'(1);
         end else if (op_cnt[dec_c.op] != CNT_MAX) begin
            op_cnt[dec_c.op] <= op_cnt[dec_c.op] + CNT_W'(1);
         end
      end
   end

endmodule
